// File: rtl/mc_datapath_pkg.sv
// mc_datapath_pkg: shared definitions for the multicycle MIPS-subset datapath.
//   - opcode / funct encodings
//   - FSM state and ALU operation encodings
//   - instruction field layout (instr_t) and sign-extension helper
//   - RESET_PC default
package mc_datapath_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_op_t;

    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mc_datapath_alu.sv
// mc_alu: combinational 32-bit ALU.
//   alu_op  in   ALU operation (add/sub/and/or/slt)
//   a, b    in   32-bit operands
//   y       out  result, arithmetic mod 2^32; slt compares signed
//   zero    out  y == 0, used for branch decisions
module mc_alu
    import mc_datapath_pkg::*;
(
    input  alu_op_t     alu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y,
    output logic        zero
);

    always_comb begin
        y = a + b;
        case (alu_op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = {31'd0, $signed(a) < $signed(b)};
            default: y = a + b;
        endcase
    end

    assign zero = (y == 32'd0);

endmodule

// File: rtl/mc_datapath.sv
// mc_datapath: multicycle MIPS-subset datapath with its FSM controller.
// One instruction runs FETCH..WB over a single shared req/ready memory port.
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   mem_req/we/addr/wdata  memory request; held stable until mem_ready
//   mem_rdata, mem_ready   read data and transaction completion
//   op, func_code, pc      IR[31:26], IR[5:0], current PC (observation)
//   retire                 one-cycle pulse per completed instruction
//   illegal                sticky unsupported-encoding flag (core parks in TRAP)
// Build option: define MC_DATAPATH_BNE_EN to make bne (op 05) legal.
module mc_datapath
    import mc_datapath_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          REG_COUNT = 32
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [5:0]  op,
    output logic [5:0]  func_code,
    output logic [31:0] pc,
    output logic        retire,
    output logic        illegal
);

    localparam int RW = $clog2(REG_COUNT);

    state_t      state, state_nx;
    instr_t      ir;
    logic [31:0] a_reg, b_reg, tgt, alu_out, mdr;
    logic [31:0] regs [REG_COUNT];

    logic [31:0] imm_sx, alu_b, alu_y;
    alu_op_t     alu_op;
    logic        alu_zero, legal, take_branch;
    logic [RW-1:0] rs_idx, rt_idx, wb_idx;
    logic [31:0] wb_data;

    assign op        = ir.op;
    assign func_code = ir.funct;
    assign imm_sx    = sext16({ir.rd, ir.shamt, ir.funct});
    assign rs_idx    = ir.rs[RW-1:0];
    assign rt_idx    = ir.rt[RW-1:0];
    assign wb_idx    = (ir.op == OP_RTYPE) ? ir.rd[RW-1:0] : rt_idx;
    assign wb_data   = (ir.op == OP_LW) ? mdr : alu_out;

    always_comb begin
        legal = 1'b0;
        case (ir.op)
            OP_RTYPE: legal = ir.funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
`ifdef MC_DATAPATH_BNE_EN
            OP_BNE: legal = 1'b1;
`endif
            default: legal = 1'b0;
        endcase
    end

    // Branches compare by subtraction so the ALU zero flag decides them.
    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = imm_sx;
        if (ir.op == OP_RTYPE) begin
            alu_b = b_reg;
            case (ir.funct)
                FN_SUB:  alu_op = ALU_SUB;
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_SLT:  alu_op = ALU_SLT;
                default: alu_op = ALU_ADD;
            endcase
        end else if (ir.op == OP_BEQ || ir.op == OP_BNE) begin
            alu_b  = b_reg;
            alu_op = ALU_SUB;
        end
    end

    mc_alu u_alu (
        .alu_op (alu_op),
        .a      (a_reg),
        .b      (alu_b),
        .y      (alu_y),
        .zero   (alu_zero)
    );

    always_comb begin
        take_branch = (ir.op == OP_BEQ) && alu_zero;
`ifdef MC_DATAPATH_BNE_EN
        take_branch = take_branch || ((ir.op == OP_BNE) && !alu_zero);
`endif
    end

    always_comb begin
        state_nx  = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc;
        mem_wdata = b_reg;
        retire    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) state_nx = S_DECODE;
            end
            S_DECODE: state_nx = legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                case (ir.op)
                    OP_RTYPE, OP_ADDI: state_nx = S_WB;
                    OP_LW, OP_SW:      state_nx = S_MEM;
                    default: begin     // beq / bne / j finish here
                        retire   = 1'b1;
                        state_nx = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_addr = alu_out;
                mem_we   = (ir.op == OP_SW);
                if (mem_ready) begin
                    retire   = (ir.op == OP_SW);
                    state_nx = (ir.op == OP_SW) ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                retire   = 1'b1;
                state_nx = S_FETCH;
            end
            default: state_nx = S_TRAP;
        endcase
        // Reset drops any in-flight request immediately; state is FETCH
        // while reset is held, which must not look like a request.
        if (reset) begin
            mem_req = 1'b0;
            retire  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            tgt     <= '0;
            alu_out <= '0;
            mdr     <= '0;
            illegal <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_FETCH: if (mem_ready) begin
                    ir <= instr_t'(mem_rdata);
                    pc <= pc + 32'd4;
                end
                S_DECODE: begin
                    a_reg <= regs[rs_idx];
                    b_reg <= regs[rt_idx];
                    tgt   <= pc + (imm_sx << 2);
                    if (!legal) illegal <= 1'b1;
                end
                S_EXEC: begin
                    alu_out <= alu_y;
                    if (take_branch) pc <= tgt;
                    if (ir.op == OP_J) pc <= {pc[31:28], ir[25:0], 2'b00};
                end
                S_MEM: if (mem_ready && ir.op == OP_LW) mdr <= mem_rdata;
                S_WB: if (wb_idx != '0) regs[wb_idx] <= wb_data;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_datapath.sv
// Scoreboard bench for mc_datapath: stimulus loads small programs into a
// bench memory and queues the expected retire PCs and store writes; a
// monitor pops and compares whenever the core retires or writes.
module tb_mc_datapath;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, mem_ready, retire, illegal;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic [5:0]  op, func_code;

    mc_datapath dut (
        .clock(clock), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .op(op), .func_code(func_code), .pc(pc),
        .retire(retire), .illegal(illegal)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        kind;   // 0 retire (a = pc afterwards), 1 write
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem [256];
    int          delay = 0;
    int          checks = 0;
    int          errors = 0;
    logic        ret_pend = 1'b0;

    function automatic logic [31:0] enc_i(input logic [5:0] o, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {o, rs, rt, imm};
    endfunction
    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction
    function automatic logic [31:0] enc_j(input logic [25:0] t);
        return {6'h02, t};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, want);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic exp_ret(input logic [31:0] p);
        q.push_back('{kind: 1'b0, a: p, d: 32'd0});
    endtask
    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        q.push_back('{kind: 1'b1, a: a, d: d});
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((q.size() != 0 || ret_pend) && n < 400) begin
            tick();
            n++;
        end
        chk({nm, "_drain_timeout"}, {31'd0, n >= 400}, 32'd0);
    endtask

    // Ticks until a retire pulse; n = ticks taken.
    task automatic wait_ret(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!retire && n < 100);
        if (n >= 100) chk("retire_timeout", 32'd1, 32'd0);
    endtask

    // Core must be parked: illegal set, no request for 10 cycles, then
    // reset clears the flag.
    task automatic trap_check(input string nm, input logic [5:0] want_op);
        int any_req = 0;
        reset = 1'b0;
        repeat (5) tick();
        chk({nm, "_illegal"}, {31'd0, illegal}, 32'd1);
        chk({nm, "_op"}, {26'd0, op}, {26'd0, want_op});
        repeat (10) begin
            tick();
            if (mem_req) any_req++;
        end
        chk({nm, "_req_quiet"}, any_req, 32'd0);
        reset = 1'b1;
        tick();
        chk({nm, "_reset_illegal"}, {31'd0, illegal}, 32'd0);
        chk({nm, "_reset_req"}, {31'd0, mem_req}, 32'd0);
    endtask

    // Memory responder: decides mem_ready for the coming edge after
    // 'delay' wait cycles; stores are committed when acknowledged.
    initial begin
        int cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clock);
            if (mem_ready) cnt = 0;
            mem_ready = 1'b0;
            if (mem_req && !reset) begin
                if (cnt >= delay) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem[mem_addr[9:2]];
                    if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: scoreboard pops plus request-stability during waits.
    initial begin
        logic        prev_wait = 1'b0, prev_we = 1'b0;
        logic [31:0] prev_addr = 32'd0, prev_wdata = 32'd0;
        exp_t        e;
        forever begin
            tick();
            if (ret_pend) begin
                ret_pend = 1'b0;
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_retire got pc %h want none", pc);
                end else begin
                    e = q.pop_front();
                    chk("ev_kind_ret", 32'd0, {31'd0, e.kind});
                    chk("retire_pc", pc, e.a);
                end
            end
            if (mem_req && mem_we && mem_ready) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write got %h=%h want none", mem_addr, mem_wdata);
                end else begin
                    e = q.pop_front();
                    chk("ev_kind_wr", 32'd1, {31'd0, e.kind});
                    chk("wr_addr", mem_addr, e.a);
                    chk("wr_data", mem_wdata, e.d);
                end
            end
            if (retire) ret_pend = 1'b1;
            if (prev_wait && mem_req) begin
                chk("stable_addr", mem_addr, prev_addr);
                chk("stable_we", {31'd0, mem_we}, {31'd0, prev_we});
                if (mem_we) chk("stable_wdata", mem_wdata, prev_wdata);
            end
            prev_wait  = mem_req && !mem_ready;
            prev_addr  = mem_addr;
            prev_we    = mem_we;
            prev_wdata = mem_wdata;
        end
    end

    initial begin
        int n;
        // 1: reset state, first fetch, addi timing, R1 observed via a store
        clear_mem();
        mem[0] = enc_i(6'h08, 0, 1, 16'd5);
        mem[1] = enc_i(6'h2B, 0, 1, 16'h0080);
        exp_ret(32'h4); exp_wr(32'h80, 32'd5); exp_ret(32'h8);
        repeat (3) tick();
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_op", {26'd0, op}, 32'd0);
        chk("rst_func", {26'd0, func_code}, 32'd0);
        reset = 1'b0;
        tick();
        chk("first_req", {31'd0, mem_req}, 32'd1);
        chk("first_addr", mem_addr, 32'h0);
        n = 0;
        while (!(mem_req && mem_ready) && n < 20) begin tick(); n++; end
        n = 1;
        while (!retire && n < 20) begin tick(); n++; end
        chk("addi_cycles", n, 32'd4);
        drain("t1");
        repeat (3) tick();
        chk("t1_trap", {31'd0, illegal}, 32'd1);
        chk("t1_trap_req", {31'd0, mem_req}, 32'd0);
        reset = 1'b1;

        // 2: ALU program incl. signed slt and r0 write-ignore
        clear_mem();
        mem[0]  = enc_i(6'h08, 0, 1, 16'd7);
        mem[1]  = enc_i(6'h08, 0, 2, 16'hFFFD);
        mem[2]  = enc_r(1, 2, 3, 6'h20);
        mem[3]  = enc_r(2, 1, 4, 6'h2A);
        mem[4]  = enc_r(2, 1, 6, 6'h22);
        mem[5]  = enc_r(1, 2, 7, 6'h24);
        mem[6]  = enc_r(1, 2, 8, 6'h25);
        mem[7]  = enc_i(6'h08, 0, 0, 16'd9);
        mem[8]  = enc_i(6'h2B, 0, 3, 16'h0080);
        mem[9]  = enc_i(6'h2B, 0, 4, 16'h0084);
        mem[10] = enc_i(6'h2B, 0, 6, 16'h0088);
        mem[11] = enc_i(6'h2B, 0, 7, 16'h008C);
        mem[12] = enc_i(6'h2B, 0, 8, 16'h0090);
        mem[13] = enc_i(6'h2B, 0, 0, 16'h0094);
        for (int i = 1; i <= 8; i++) exp_ret(32'(4 * i));
        exp_wr(32'h80, 32'd4);          exp_ret(32'd36);
        exp_wr(32'h84, 32'd1);          exp_ret(32'd40);
        exp_wr(32'h88, 32'hFFFF_FFF6);  exp_ret(32'd44);
        exp_wr(32'h8C, 32'd5);          exp_ret(32'd48);
        exp_wr(32'h90, 32'hFFFF_FFFF);  exp_ret(32'd52);
        exp_wr(32'h94, 32'd0);          exp_ret(32'd56);
        tick();
        reset = 1'b0;
        drain("t2");
        reset = 1'b1;

        // 3: store/load with 3 wait cycles per access, code at 0x100
        clear_mem();
        delay = 3;
        mem[0]  = enc_j(26'h40);
        mem[64] = enc_i(6'h08, 0, 1, 16'd7);
        mem[65] = enc_i(6'h2B, 0, 1, 16'd8);
        mem[66] = enc_i(6'h23, 0, 5, 16'd8);
        mem[67] = enc_i(6'h2B, 0, 5, 16'h0080);
        exp_ret(32'h100); exp_ret(32'h104); exp_wr(32'h8, 32'd7);
        exp_ret(32'h108); exp_ret(32'h10C); exp_wr(32'h80, 32'd7);
        exp_ret(32'h110);
        tick();
        reset = 1'b0;
        drain("t3");
        reset = 1'b1;
        delay = 0;

        // 4a: beq r1,r1,-1 at 0x20 loops onto itself in 3 cycles
        clear_mem();
        mem[0] = enc_j(26'h8);
        mem[8] = enc_i(6'h04, 1, 1, 16'hFFFF);
        exp_ret(32'h20); exp_ret(32'h20); exp_ret(32'h20);
        tick();
        reset = 1'b0;
        wait_ret(n);
        wait_ret(n);
        chk("beq_cycles", n, 32'd3);
        drain("t4a");
        reset = 1'b1;

        // 4b: beq not taken falls through; j 0x40 at 0x24 -> 0x100
        clear_mem();
        mem[0] = enc_i(6'h08, 0, 1, 16'd1);
        mem[1] = enc_j(26'h8);
        mem[8] = enc_i(6'h04, 0, 1, 16'hFFFF);
        mem[9] = enc_j(26'h40);
        exp_ret(32'h4); exp_ret(32'h20); exp_ret(32'h24); exp_ret(32'h100);
        tick();
        reset = 1'b0;
        drain("t4b");
        reset = 1'b1;

        // 5: unsupported opcodes park the core
        clear_mem();
        mem[0] = 32'hFC00_0000;
        tick();
        trap_check("op3f", 6'h3F);
        clear_mem();
`ifdef MC_DATAPATH_BNE_EN
        mem[0] = enc_i(6'h08, 0, 1, 16'd1);
        mem[1] = enc_i(6'h05, 1, 0, 16'd2);
        exp_ret(32'h4); exp_ret(32'h10);
        tick();
        reset = 1'b0;
        drain("bne");
        reset = 1'b1;
`else
        mem[0] = enc_i(6'h05, 0, 1, 16'd2);
        tick();
        trap_check("op05", 6'h05);
`endif

        // 6: reset during the MEM wait of a store abandons it
        clear_mem();
        delay = 4;
        mem[0] = enc_i(6'h08, 0, 1, 16'd7);
        mem[1] = enc_i(6'h2B, 0, 1, 16'h0080);
        exp_ret(32'h4);
        tick();
        reset = 1'b0;
        drain("t6");
        n = 0;
        while (!(mem_req && mem_we) && n < 60) begin tick(); n++; end
        chk("t6_reach_mem", {31'd0, n >= 60}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("t6_req_drop", {31'd0, mem_req}, 32'd0);
        chk("t6_pc", pc, 32'h0);
        repeat (8) tick();
        chk("t6_no_store", mem[32], 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
